// File: rtl/mismatch_scoreboard.sv
// Reference-vs-DUT comparison scoreboard: counts samples and mismatches,
// latches the first failing index and hands a pass/fail report downstream.
module mismatch_scoreboard #(
    parameter int WIDTH       = 1,
    parameter int CNT_W       = 32,
    parameter int MAX_SAMPLES = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] ref_val,
    input  logic [WIDTH-1:0] dut_val,
    output logic             busy,
    output logic             mismatch,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_valid,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

    state_t           state;
    state_t           state_nxt;
    logic             miss;
    logic             hit_max;
    logic [CNT_W-1:0] samples_inc;
    logic [CNT_W-1:0] errors_inc;

    assign miss = (ref_val != dut_val);

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign samples_inc = (samples == CNT_MAX) ? samples : samples + CNT_W'(1);
    assign errors_inc  = (errors == CNT_MAX) ? errors : errors + CNT_W'(1);
    assign hit_max     = (MAX_SAMPLES != 0) && (samples_inc == MAX_CNT);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        rpt_valid = 1'b0;
        pass      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (stop || (sample_en && hit_max))
                    state_nxt = REPORT;
            end
            REPORT: begin
                rpt_valid = 1'b1;
                pass      = (errors == '0);
                if (rpt_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            mismatch        <= 1'b0;
            samples         <= '0;
            errors          <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            mismatch <= 1'b0;
            if (state == IDLE && start) begin
                samples         <= '0;
                errors          <= '0;
                first_err_idx   <= '0;
                first_err_valid <= 1'b0;
            end else if (state == RUN && sample_en) begin
                samples  <= samples_inc;
                mismatch <= miss;
                if (miss) begin
                    errors <= errors_inc;
                    // Index is the pre-increment count, i.e. 0-based.
                    if (!first_err_valid) begin
                        first_err_idx   <= samples;
                        first_err_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mismatch_scoreboard.sv
// Randomized scoreboard bench for mismatch_scoreboard: a queue-based run
// model predicts counters per cycle and the report contents per run.
module tb_mismatch_scoreboard;

    localparam int W    = 4;
    localparam int CW   = 32;
    localparam int MAXS = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, stop, sample_en, rpt_ready;
    logic [W-1:0]  ref_val, dut_val;
    logic          busy, mismatch, first_err_valid, rpt_valid, pass;
    logic [CW-1:0] samples, errors, first_err_idx;

    mismatch_scoreboard #(.WIDTH(W), .CNT_W(CW), .MAX_SAMPLES(MAXS)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_en(sample_en), .ref_val(ref_val), .dut_val(dut_val),
        .busy(busy), .mismatch(mismatch), .samples(samples),
        .errors(errors), .first_err_idx(first_err_idx),
        .first_err_valid(first_err_valid), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .pass(pass)
    );

    // Small saturating instance: 3-bit counters, unlimited run length.
    logic       s2_start, s2_stop, s2_se, s2_ref, s2_dut, s2_ready;
    logic       s2_busy, s2_mm, s2_fev, s2_rv, s2_pass;
    logic [2:0] s2_samples, s2_errors, s2_idx;

    mismatch_scoreboard #(.WIDTH(1), .CNT_W(3), .MAX_SAMPLES(0)) dut2 (
        .clk(clk), .reset(reset), .start(s2_start), .stop(s2_stop),
        .sample_en(s2_se), .ref_val(s2_ref), .dut_val(s2_dut),
        .busy(s2_busy), .mismatch(s2_mm), .samples(s2_samples),
        .errors(s2_errors), .first_err_idx(s2_idx),
        .first_err_valid(s2_fev), .rpt_valid(s2_rv),
        .rpt_ready(s2_ready), .pass(s2_pass)
    );

    typedef enum {P_IDLE, P_RUN, P_RPT} phase_t;
    typedef struct {
        int unsigned s;
        int unsigned e;
        int unsigned i;
        bit          v;
        bit          p;
    } rpt_t;

    int     nchk = 0;
    int     nerr = 0;
    phase_t phase = P_IDLE;
    bit     bits[$];
    rpt_t   exp_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Report view of the current/last run, from its list of outcomes.
    function automatic rpt_t summarize();
        rpt_t r;
        r.s = bits.size();
        r.e = 0;
        r.i = 0;
        r.v = 1'b0;
        foreach (bits[k]) begin
            if (bits[k]) begin
                if (!r.v) begin
                    r.i = k;
                    r.v = 1'b1;
                end
                r.e++;
            end
        end
        r.p = (r.e == 0);
        return r;
    endfunction

    task automatic step(input logic rs, st, sp, se,
                        input logic [W-1:0] r, d, input logic rr);
        bit   prev_run;
        bit   exp_mm;
        rpt_t m;
        reset     = rs;
        start     = st;
        stop      = sp;
        sample_en = se;
        ref_val   = r;
        dut_val   = d;
        rpt_ready = rr;
        prev_run  = (phase == P_RUN) && !rs;
        exp_mm    = prev_run && se && (r != d);
        if (rs) begin
            phase = P_IDLE;
            bits.delete();
        end else begin
            case (phase)
                P_IDLE: if (st) begin
                    phase = P_RUN;
                    bits.delete();
                end
                P_RUN: begin
                    if (se)
                        bits.push_back(r != d);
                    if (sp || (se && MAXS != 0 && bits.size() == MAXS)) begin
                        exp_q.push_back(summarize());
                        phase = P_RPT;
                    end
                end
                default: if (rr) phase = P_IDLE;
            endcase
        end
        @(posedge clk);
        #2;
        m = summarize();
        chk("samples", samples, m.s);
        chk("errors", errors, m.e);
        chk("first_err_idx", first_err_idx, m.i);
        chk("first_err_valid", first_err_valid, m.v);
        chk("busy", busy, phase == P_RUN);
        chk("rpt_valid", rpt_valid, phase == P_RPT);
        chk("pass", pass, phase == P_RPT && m.e == 0);
        if (prev_run || rs)
            chk("mismatch", mismatch, exp_mm);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, rr);
    endtask

    task automatic go();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic sample(input bit bad, input logic sp);
        logic [W-1:0] r;
        logic [W-1:0] d;
        r = W'($urandom);
        d = bad ? r ^ (W'(1) << $urandom_range(0, W - 1)) : r;
        step(1'b0, 1'b0, sp, 1'b1, r, d, 1'b0);
    endtask

    task automatic tick2();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; sample_en = 1'b0;
        rpt_ready = 1'b0; ref_val = '0; dut_val = '0;
        s2_start = 1'b0; s2_stop = 1'b0; s2_se = 1'b0;
        s2_ref = 1'b0; s2_dut = 1'b0; s2_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rpt_valid === 1'b1 && rpt_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        nchk++;
                        nerr++;
                        $display("FAIL unexpected_report: got 1 expected 0");
                    end else begin
                        rpt_t e;
                        e = exp_q.pop_front();
                        chk("rpt_samples", samples, e.s);
                        chk("rpt_errors", errors, e.e);
                        chk("rpt_first_idx", first_err_idx, e.i);
                        chk("rpt_first_valid", first_err_valid, e.v);
                        chk("rpt_pass", pass, e.p);
                    end
                end
            end
        join_none

        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // 100 matching samples, then stop and immediate accept.
        go();
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, W'(1), W'(1), 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // First mismatch at index 10 plus three later ones.
        go();
        for (int i = 0; i < 20; i++)
            sample(i == 10 || i == 13 || i == 15 || i == 18, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1'b1);

        // Auto-terminate at MAX_SAMPLES; later samples ignored.
        go();
        for (int i = 0; i < MAXS + 5; i++)
            sample($urandom_range(0, 3) == 0, 1'b0);
        idle(1'b1);

        // stop together with a mismatched sample at index 5.
        go();
        for (int i = 0; i < 5; i++)
            sample(1'b0, 1'b0);
        sample(1'b1, 1'b1);
        idle(1'b1);

        // Reset mid-run aborts without a report.
        go();
        for (int i = 0; i < 7; i++)
            sample(i == 2 || i == 5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1'b0);

        // Report held while start/sample_en toggle; then a new start clears.
        go();
        for (int i = 0; i < 8; i++)
            sample($urandom_range(0, 1) == 1, 1'b0);
        sample(1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'b0, i[0], ~i[0], ~i[0], W'($urandom), W'($urandom), 1'b0);
        idle(1'b1);
        go();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1'b1);

        // start+stop in IDLE starts only; zero-sample run passes.
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1'b1);

        // Random runs with random gaps and accept delays.
        for (int n = 0; n < 25; n++) begin
            int len;
            go();
            len = $urandom_range(0, 30);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0)
                    idle(1'b0);
                else
                    sample($urandom_range(0, 4) == 0, 1'b0);
            end
            if ($urandom_range(0, 1) == 1)
                sample($urandom_range(0, 1) == 1, 1'b1);
            else
                step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
            repeat ($urandom_range(0, 3)) idle(1'b0);
            idle(1'b1);
        end

        // Saturation on the 3-bit instance.
        s2_start = 1'b1;
        tick2();
        s2_start = 1'b0;
        s2_se = 1'b1; s2_ref = 1'b1; s2_dut = 1'b0;
        repeat (10) tick2();
        s2_se = 1'b0;
        s2_stop = 1'b1;
        tick2();
        s2_stop = 1'b0;
        chk("sat_samples", s2_samples, 7);
        chk("sat_errors", s2_errors, 7);
        chk("sat_first_idx", s2_idx, 0);
        chk("sat_first_valid", s2_fev, 1);
        chk("sat_rpt_valid", s2_rv, 1);
        chk("sat_pass", s2_pass, 0);
        s2_ready = 1'b1;
        tick2();
        s2_ready = 1'b0;
        chk("sat_rpt_done", s2_rv, 0);

        chk("reports_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mismatch_scoreboard.md
Name: mismatch_scoreboard

Overview:
- Downstream checker stage for the reference-vs-DUT comparison flow.
- Consumes a reference output vector and a DUT output vector each sample and counts total samples and mismatched samples.
- Captures the index of the first mismatch and presents a pass/fail report through a valid/ready handshake.
- Synthesizable replacement for the bench-side error statistics, so the comparison can run in hardware alongside the DUT.

Parameters:
- WIDTH, 1, width of compared output vectors.
- CNT_W, 32, width of the sample, error and first-index counters.
- MAX_SAMPLES, 200, sample count that auto-terminates a run; 0 = unlimited.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; honoured only in IDLE.
- stop  in  1  end a run; honoured only in RUN.
- sample_en  in  1  compare ref_val and dut_val this cycle.
- ref_val  in  WIDTH  golden output.
- dut_val  in  WIDTH  DUT output.
- busy  out  1  high in RUN.
- mismatch  out  1  registered: previous accepted sample mismatched.
- samples  out  CNT_W  accepted samples in current/last run.
- errors  out  CNT_W  mismatched samples.
- first_err_idx  out  CNT_W  sample index (0-based) of first mismatch.
- first_err_valid  out  1  first_err_idx is meaningful.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  report consumer accepts.
- pass  out  1  errors==0; meaningful while rpt_valid.

Behaviour:
- Reset: state=IDLE; all outputs 0.
- Reset mid-run or mid-report aborts to IDLE and clears everything, with no report.
- States: IDLE, RUN, REPORT.
- IDLE -> RUN on start. samples, errors, first_err_idx, first_err_valid and mismatch all clear to 0 on that edge.
- In IDLE, counter outputs hold the last run's values until the next start.
- RUN, on each cycle with sample_en=1:
  - samples <= samples+1.
  - mismatch <= (ref_val != dut_val), compared over the full WIDTH.
  - On a mismatch, errors <= errors+1.
  - If first_err_valid=0 at a mismatch, capture first_err_idx <= pre-increment samples and set first_err_valid=1. It never updates again within the run.
- RUN, cycle with sample_en=0: counters hold; mismatch <= 0.
- Latency: all counter/flag outputs reflect a sample on the clock edge after sample_en is high.
- Counters saturate at 2^CNT_W-1 and never wrap.
- RUN -> REPORT when either:
  - stop=1, or
  - MAX_SAMPLES!=0 and the accepted sample brings samples to MAX_SAMPLES.
- stop and sample_en in the same cycle: the sample is counted, then REPORT.
- REPORT:
  - rpt_valid=1 and pass=(errors==0); counters frozen.
  - sample_en and stop are ignored.
  - When rpt_valid&rpt_ready -> IDLE; rpt_valid drops the next cycle. rpt_valid and pass are 0 outside REPORT.
- start in RUN or REPORT is ignored. start and stop together in IDLE: start only.
- A run with zero samples reports pass=1, samples=0, first_err_valid=0.

Test Plan:
- reset, start, 100 samples with ref=dut=1'b1, stop -> samples=100, errors=0, first_err_valid=0, rpt_valid=1, pass=1. rpt_ready=1 -> IDLE next cycle, rpt_valid=0.
- start, samples 0..9 matching, sample 10 mismatched (ref=1, dut=0), samples 11..19 with 3 more mismatches, stop -> samples=20, errors=4, first_err_idx=10, first_err_valid=1, pass=0. mismatch pulses the cycle after each bad sample.
- MAX_SAMPLES=200, start, sample_en continuous, no stop -> REPORT entered on the edge where samples=200; a sample_en asserted after that is ignored and samples stays 200.
- stop and sample_en (mismatched) in the same cycle at sample 5 -> samples=6, errors=1, first_err_idx=5, REPORT.
- Reset asserted mid-run after 7 samples with 2 errors -> next cycle state IDLE, all outputs 0, busy=0, no rpt_valid.
- REPORT with rpt_ready held low 10 cycles while start and sample_en toggle -> rpt_valid stays 1, counters unchanged. Then rpt_ready=1 -> IDLE; a following start clears the counters.
